riscv_memaccess_router: RTL and testbench

- Stage directly downstream of the physical memory attributes checker.
- Registers each checked memory access and steers it to one of three targets: cache, external bus or TCM.
- Accesses the checker flagged as access-fault or misaligned are never issued downstream; the block answers them locally with an error response.
- All responses return to the requester in strict request order, tracked by an outstanding-transaction tag FIFO.

---
 rtl/riscv_memaccess_router.sv | 226 ++++++++++++++++++++++
 tb/tb_riscv_memaccess_router.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_memaccess_router.sv
// Routes PMA-checked memory accesses to cache, external bus or TCM, answers faulting
// accesses locally, and returns all responses in request order via a tag FIFO.
module riscv_memaccess_router #(
    parameter int XLEN  = 64,
    parameter int PLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            req_i,
    output logic            ready_o,
    input  logic [PLEN-1:0] adr_i,
    input  logic [2:0]      size_i,
    input  logic            lock_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] d_i,
    input  logic            exception_i,
    input  logic            misaligned_i,
    input  logic            is_cache_access_i,
    input  logic            is_ext_access_i,
    input  logic            is_tcm_access_i,

    output logic            c_req_o,
    input  logic            c_gnt_i,
    output logic [PLEN-1:0] c_adr_o,
    output logic [2:0]      c_size_o,
    output logic            c_lock_o,
    output logic            c_we_o,
    output logic [XLEN-1:0] c_d_o,
    input  logic            c_rsp_valid_i,
    output logic            c_rsp_ready_o,
    input  logic [XLEN-1:0] c_q_i,
    input  logic            c_err_i,

    output logic            e_req_o,
    input  logic            e_gnt_i,
    output logic [PLEN-1:0] e_adr_o,
    output logic [2:0]      e_size_o,
    output logic            e_lock_o,
    output logic            e_we_o,
    output logic [XLEN-1:0] e_d_o,
    input  logic            e_rsp_valid_i,
    output logic            e_rsp_ready_o,
    input  logic [XLEN-1:0] e_q_i,
    input  logic            e_err_i,

    output logic            t_req_o,
    input  logic            t_gnt_i,
    output logic [PLEN-1:0] t_adr_o,
    output logic [2:0]      t_size_o,
    output logic            t_lock_o,
    output logic            t_we_o,
    output logic [XLEN-1:0] t_d_o,
    input  logic            t_rsp_valid_i,
    output logic            t_rsp_ready_o,
    input  logic [XLEN-1:0] t_q_i,
    input  logic            t_err_i,

    output logic            ack_o,
    output logic [XLEN-1:0] q_o,
    output logic            err_o,
    output logic            misaligned_o
);

    localparam int          PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic [2:0] {
        TAG_CACHE     = 3'd0,
        TAG_EXT       = 3'd1,
        TAG_TCM       = 3'd2,
        TAG_LOCAL_ACC = 3'd4,
        TAG_LOCAL_MIS = 3'd5
    } tag_t;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t          state;
    tag_t            tag_mem [DEPTH];
    tag_t            push_tag;
    tag_t            head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic [2:0]      tgt_req;
    logic [2:0]      gnt;
    logic [2:0]      rsp_hit;
    logic [PLEN-1:0] adr_q;
    logic [2:0]      size_q;
    logic            lock_q;
    logic            we_q;
    logic [XLEN-1:0] d_q;
    logic            full;
    logic            empty;
    logic            accept;
    logic            fault;
    logic            head_local;
    logic            local_ready;
    logic            local_pop;
    logic            pop;

    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign ready_o    = !rst_i && (state == IDLE) && !full;
    assign accept     = req_i && ready_o;
    assign fault      = exception_i || misaligned_i ||
                        !(is_cache_access_i || is_ext_access_i || is_tcm_access_i);
    assign head       = tag_mem[rd_ptr];
    assign head_local = !empty && head[2];

    assign c_rsp_ready_o = !empty && (head == TAG_CACHE);
    assign e_rsp_ready_o = !empty && (head == TAG_EXT);
    assign t_rsp_ready_o = !empty && (head == TAG_TCM);

    assign gnt     = {t_gnt_i, e_gnt_i, c_gnt_i};
    assign rsp_hit = {t_rsp_valid_i && t_rsp_ready_o,
                      e_rsp_valid_i && e_rsp_ready_o,
                      c_rsp_valid_i && c_rsp_ready_o};

    // A local fault must sit at the head for one full cycle before it is answered.
    assign local_pop = head_local && local_ready;
    assign pop       = (|rsp_hit) || local_pop;
    assign ack_o     = pop;

    always_comb begin
        push_tag = TAG_LOCAL_ACC;
        if (exception_i)            push_tag = TAG_LOCAL_ACC;
        else if (misaligned_i)      push_tag = TAG_LOCAL_MIS;
        else if (is_cache_access_i) push_tag = TAG_CACHE;
        else if (is_ext_access_i)   push_tag = TAG_EXT;
        else if (is_tcm_access_i)   push_tag = TAG_TCM;
    end

    always_comb begin
        q_o          = '0;
        err_o        = 1'b0;
        misaligned_o = 1'b0;
        if (rsp_hit[0]) begin
            q_o   = c_q_i;
            err_o = c_err_i;
        end else if (rsp_hit[1]) begin
            q_o   = e_q_i;
            err_o = e_err_i;
        end else if (rsp_hit[2]) begin
            q_o   = t_q_i;
            err_o = t_err_i;
        end else if (local_pop) begin
            err_o        = (head == TAG_LOCAL_ACC);
            misaligned_o = (head == TAG_LOCAL_MIS);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            local_ready <= 1'b0;
            for (int i = 0; i < DEPTH; i++) tag_mem[i] <= TAG_CACHE;
        end else begin
            if (accept) begin
                tag_mem[wr_ptr] <= push_tag;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (accept && !pop)      count <= count + (PW+1)'(1);
            else if (!accept && pop) count <= count - (PW+1)'(1);
            local_ready <= head_local && !pop;
        end
    end

    // Single issue slot: payload is captured on accept and held until the target grants.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            tgt_req <= '0;
            adr_q   <= '0;
            size_q  <= '0;
            lock_q  <= 1'b0;
            we_q    <= 1'b0;
            d_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && !fault) begin
                        adr_q   <= adr_i;
                        size_q  <= size_i;
                        lock_q  <= lock_i;
                        we_q    <= we_i;
                        d_q     <= d_i;
                        tgt_req <= 3'b001 << push_tag[1:0];
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (|(tgt_req & gnt)) begin
                        tgt_req <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign c_req_o  = tgt_req[0];
    assign e_req_o  = tgt_req[1];
    assign t_req_o  = tgt_req[2];
    assign c_adr_o  = adr_q;
    assign e_adr_o  = adr_q;
    assign t_adr_o  = adr_q;
    assign c_size_o = size_q;
    assign e_size_o = size_q;
    assign t_size_o = size_q;
    assign c_lock_o = lock_q;
    assign e_lock_o = lock_q;
    assign t_lock_o = lock_q;
    assign c_we_o   = we_q;
    assign e_we_o   = we_q;
    assign t_we_o   = we_q;
    assign c_d_o    = d_q;
    assign e_d_o    = d_q;
    assign t_d_o    = d_q;

endmodule

// File: tb/tb_riscv_memaccess_router.sv
// Self-checking bench for riscv_memaccess_router: directed scenarios followed by random
// traffic, all compared each cycle against an in-order response queue model.
module tb_riscv_memaccess_router;

    localparam int XLEN  = 64;
    localparam int PLEN  = 64;
    localparam int DEPTH = 2;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    logic                 req_i, lock_i, we_i, exception_i, misaligned_i;
    logic                 is_cache_access_i, is_ext_access_i, is_tcm_access_i;
    logic [PLEN-1:0]      adr_i;
    logic [2:0]           size_i;
    logic [XLEN-1:0]      d_i;
    logic [2:0]           gnt_v, rsp_valid_v, err_v;
    logic [2:0][XLEN-1:0] q_v;

    wire                  ready_o, ack_o, err_o, misaligned_o;
    wire [XLEN-1:0]       q_o;
    wire [2:0]            req_v, rsp_ready_v, lock_v, we_v;
    wire [2:0][PLEN-1:0]  adr_v;
    wire [2:0][2:0]       size_v;
    wire [2:0][XLEN-1:0]  d_v;

    riscv_memaccess_router #(.XLEN(XLEN), .PLEN(PLEN), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_i(req_i), .ready_o(ready_o), .adr_i(adr_i), .size_i(size_i),
        .lock_i(lock_i), .we_i(we_i), .d_i(d_i),
        .exception_i(exception_i), .misaligned_i(misaligned_i),
        .is_cache_access_i(is_cache_access_i), .is_ext_access_i(is_ext_access_i),
        .is_tcm_access_i(is_tcm_access_i),
        .c_req_o(req_v[0]), .c_gnt_i(gnt_v[0]), .c_adr_o(adr_v[0]), .c_size_o(size_v[0]),
        .c_lock_o(lock_v[0]), .c_we_o(we_v[0]), .c_d_o(d_v[0]),
        .c_rsp_valid_i(rsp_valid_v[0]), .c_rsp_ready_o(rsp_ready_v[0]),
        .c_q_i(q_v[0]), .c_err_i(err_v[0]),
        .e_req_o(req_v[1]), .e_gnt_i(gnt_v[1]), .e_adr_o(adr_v[1]), .e_size_o(size_v[1]),
        .e_lock_o(lock_v[1]), .e_we_o(we_v[1]), .e_d_o(d_v[1]),
        .e_rsp_valid_i(rsp_valid_v[1]), .e_rsp_ready_o(rsp_ready_v[1]),
        .e_q_i(q_v[1]), .e_err_i(err_v[1]),
        .t_req_o(req_v[2]), .t_gnt_i(gnt_v[2]), .t_adr_o(adr_v[2]), .t_size_o(size_v[2]),
        .t_lock_o(lock_v[2]), .t_we_o(we_v[2]), .t_d_o(d_v[2]),
        .t_rsp_valid_i(rsp_valid_v[2]), .t_rsp_ready_o(rsp_ready_v[2]),
        .t_q_i(q_v[2]), .t_err_i(err_v[2]),
        .ack_o(ack_o), .q_o(q_o), .err_o(err_o), .misaligned_o(misaligned_o)
    );

    int checks   = 0;
    int failures = 0;

    // Stimulus for the current cycle.
    logic            s_req, s_lock, s_we, s_exc, s_mis, s_gerr;
    logic [PLEN-1:0] s_adr;
    logic [2:0]      s_size, s_route, s_gnt, s_rsp_en;
    logic [XLEN-1:0] s_d, s_gdata;

    // Reference model: tags in acceptance order (0..2 target, 4 access fault, 5 misaligned),
    // per-target responses waiting to be delivered, and the single in-flight issue.
    int              expq[$];
    logic [XLEN:0]   pend [3][$];
    int              issuing;
    int              head_age;
    logic [2:0]      held;
    logic [PLEN-1:0] iss_adr;
    logic [2:0]      iss_size;
    logic            iss_lock, iss_we;
    logic [XLEN-1:0] iss_d;
    logic            exp_ready, exp_ack, exp_err, exp_mis;
    logic [XLEN-1:0] exp_q;

    task automatic checkVal(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setIdle();
        s_req = 0; s_lock = 0; s_we = 0; s_exc = 0; s_mis = 0; s_gerr = 0;
        s_adr = '0; s_size = '0; s_route = '0; s_gnt = '0; s_rsp_en = '0;
        s_d = '0; s_gdata = '0;
    endtask

    task automatic setAccess(input logic [PLEN-1:0] adr, input logic [2:0] route,
                             input logic exc, input logic mis);
        s_req = 1; s_adr = adr; s_route = route; s_exc = exc; s_mis = mis;
        s_size = 3'b010; s_we = 0; s_lock = 0; s_d = {$urandom, $urandom};
    endtask

    task automatic resetModel();
        expq.delete();
        issuing  = -1;
        head_age = 0;
        held     = '0;
    endtask

    function automatic int tagOf();
        if (s_exc)      return 4;
        if (s_mis)      return 5;
        if (s_route[0]) return 0;
        if (s_route[1]) return 1;
        if (s_route[2]) return 2;
        return 4;
    endfunction

    task automatic checkOutput();
        int hd;
        hd = (expq.size() > 0) ? expq[0] : -1;
        checkVal("ready_o", ready_o, exp_ready);
        for (int x = 0; x < 3; x++) begin
            checkVal($sformatf("req_o[%0d]", x), req_v[x], issuing == x);
            checkVal($sformatf("rsp_ready_o[%0d]", x), rsp_ready_v[x], hd == x);
        end
        if (issuing >= 0) begin
            checkVal("adr_o", adr_v[issuing], iss_adr);
            checkVal("size_o", size_v[issuing], iss_size);
            checkVal("lock_o", lock_v[issuing], iss_lock);
            checkVal("we_o", we_v[issuing], iss_we);
            checkVal("d_o", d_v[issuing], iss_d);
        end
        checkVal("ack_o", ack_o, exp_ack);
        if (exp_ack) checkVal("q_o", q_o, exp_q);
        checkVal("err_o", err_o, exp_err);
        checkVal("misaligned_o", misaligned_o, exp_mis);
    endtask

    task automatic updateModel();
        int  h;
        int  t;
        logic was_empty;
        was_empty = (expq.size() == 0);
        if (exp_ack) begin
            h = expq.pop_front();
            if (h < 3) begin
                void'(pend[h].pop_front());
                held[h] = 0;
            end
        end
        if (issuing >= 0 && s_gnt[issuing]) begin
            pend[issuing].push_back({s_gerr, s_gdata});
            issuing = -1;
        end
        if (s_req && exp_ready) begin
            t = tagOf();
            expq.push_back(t);
            if (t < 3) begin
                issuing  = t;
                iss_adr  = s_adr;
                iss_size = s_size;
                iss_lock = s_lock;
                iss_we   = s_we;
                iss_d    = s_d;
            end
        end
        head_age = (was_empty || exp_ack) ? 0 : head_age + 1;
    endtask

    // One clock cycle: drive inputs, predict, check at the falling edge, advance the model.
    task automatic applyStimulus();
        int h;
        req_i = s_req; adr_i = s_adr; size_i = s_size; lock_i = s_lock; we_i = s_we; d_i = s_d;
        exception_i = s_exc; misaligned_i = s_mis;
        is_cache_access_i = s_route[0]; is_ext_access_i = s_route[1]; is_tcm_access_i = s_route[2];
        gnt_v = s_gnt;
        for (int x = 0; x < 3; x++) begin
            if (pend[x].size() > 0 && (held[x] || s_rsp_en[x])) begin
                rsp_valid_v[x] = 1;
                held[x]        = 1;
                q_v[x]         = pend[x][0][XLEN-1:0];
                err_v[x]       = pend[x][0][XLEN];
            end else begin
                rsp_valid_v[x] = 0;
                q_v[x]         = {$urandom, $urandom};
                err_v[x]       = 1'($urandom_range(0, 1));
            end
        end
        exp_ready = !rst_i && (issuing < 0) && (expq.size() < DEPTH);
        exp_ack = 0; exp_q = '0; exp_err = 0; exp_mis = 0;
        if (expq.size() > 0) begin
            h = expq[0];
            if (h < 3) begin
                if (rsp_valid_v[h]) begin
                    exp_ack = 1;
                    exp_q   = pend[h][0][XLEN-1:0];
                    exp_err = pend[h][0][XLEN];
                end
            end else if (head_age >= 1) begin
                exp_ack = 1;
                exp_err = (h == 4);
                exp_mis = (h == 5);
            end
        end
        @(negedge clk_i);
        checkOutput();
        updateModel();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int r;
        rst_i = 1;
        resetModel();
        setIdle();
        repeat (2) applyStimulus();
        checkVal("reset adr_o", adr_v[1], '0);
        checkVal("reset d_o", d_v[2], '0);
        checkVal("reset size_o", size_v[0], '0);
        rst_i = 0;
        applyStimulus();

        $display("[TB] cache read");
        setAccess(64'h1000, 3'b001, 0, 0); applyStimulus();
        setIdle(); s_gnt = 3'b001; s_gdata = 64'hDEADBEEF; applyStimulus();
        setIdle(); applyStimulus();
        s_rsp_en = 3'b001; applyStimulus();
        setIdle(); applyStimulus();

        $display("[TB] local access fault");
        setAccess(64'h0, 3'b000, 1, 0); applyStimulus();
        setIdle(); repeat (3) applyStimulus();
        setAccess(64'h3, 3'b010, 0, 1); applyStimulus();
        setIdle(); repeat (3) applyStimulus();

        $display("[TB] out-of-order target responses");
        setAccess(64'h2000, 3'b010, 0, 0); applyStimulus();
        setIdle(); s_gnt = 3'b010; s_gdata = 64'hE0E0; applyStimulus();
        setAccess(64'h3000, 3'b100, 0, 0); applyStimulus();
        setIdle(); s_gnt = 3'b100; s_gdata = 64'h7070; s_gerr = 1; applyStimulus();
        setIdle(); s_rsp_en = 3'b100; repeat (3) applyStimulus();
        setIdle(); s_rsp_en = 3'b010; applyStimulus();
        setIdle(); repeat (2) applyStimulus();

        $display("[TB] full tag FIFO");
        for (int k = 0; k < 2; k++) begin
            setAccess(64'h4000 + 64'(k * 8), 3'b010, 0, 0); applyStimulus();
            setIdle(); s_gnt = 3'b010; s_gdata = 64'(k + 100); applyStimulus();
        end
        setAccess(64'h5000, 3'b010, 0, 0); repeat (2) applyStimulus();
        s_rsp_en = 3'b010; applyStimulus();
        s_rsp_en = 3'b000; applyStimulus();
        setIdle(); s_gnt = 3'b111; s_rsp_en = 3'b111; repeat (8) applyStimulus();

        $display("[TB] grant stall");
        setAccess(64'h6000, 3'b010, 0, 0); applyStimulus();
        setAccess(64'h6100, 3'b001, 0, 0); repeat (5) applyStimulus();
        setIdle(); s_gnt = 3'b010; applyStimulus();
        setIdle(); s_rsp_en = 3'b111; repeat (3) applyStimulus();

        $display("[TB] reset during issue");
        setAccess(64'h7000, 3'b010, 0, 0); applyStimulus();
        setIdle(); applyStimulus();
        rst_i = 1; resetModel(); applyStimulus();
        rst_i = 0; applyStimulus();
        pend[1].push_back({1'b0, 64'hBAD});
        s_rsp_en = 3'b010; repeat (3) applyStimulus();
        pend[1].delete(); held = '0;
        setIdle(); applyStimulus();

        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            setIdle();
            s_req  = 1'($urandom_range(0, 1));
            s_adr  = {$urandom, $urandom};
            s_size = 3'($urandom_range(0, 7));
            s_lock = 1'($urandom_range(0, 1));
            s_we   = 1'($urandom_range(0, 1));
            s_d    = {$urandom, $urandom};
            r = $urandom_range(0, 19);
            if (r < 2)       s_exc = 1;
            else if (r < 4)  s_mis = 1;
            else if (r > 4)  s_route = 3'b001 << (r % 3);
            s_gnt    = 3'($urandom_range(0, 7));
            s_rsp_en = 3'($urandom_range(0, 7));
            s_gdata  = {$urandom, $urandom};
            s_gerr   = ($urandom_range(0, 7) == 0);
            applyStimulus();
        end
        setIdle(); s_gnt = 3'b111; s_rsp_en = 3'b111; repeat (12) applyStimulus();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
